// File: rtl/io_pad_arbiter_pkg.sv
// Shared types, defaults and the round-robin search helper for io_pad_arbiter.
package io_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GRANT,
      ST_TURN
   } state_e;

   localparam int DEF_NUM_REQ    = 4;
   localparam int DEF_PAD_W      = 5;
   localparam int DEF_MAX_HOLD   = 64;
   localparam int DEF_TURNAROUND = 1;

   // Widest supported requester set; the helper works on this width.
   localparam int MAX_REQ = 8;
   localparam int IDX_W   = 3;

   typedef struct packed {
      logic             valid;
      logic [IDX_W-1:0] idx;
   } pick_t;

   // First set bit at or above ptr, wrapping within the lowest num bits.
   function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                     input logic [IDX_W-1:0]   ptr,
                                     input int                 num);
      pick_t r;
      int    j;
      r.valid = 1'b0;
      r.idx   = '0;
      for (int i = 0; i < MAX_REQ; i++) begin
         if (i < num && !r.valid) begin
            j = int'(ptr) + i;
            if (j >= num) j = j - num;
            if (req[j]) begin
               r.valid = 1'b1;
               r.idx   = IDX_W'(j);
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/io_pad_arbiter_if.sv
// Request/grant and pad bundle between the user blocks, the arbiter and the wrapper pins.
interface io_pad_arbiter_if
   import io_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int PAD_W   = DEF_PAD_W
);
   localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]       req_i;
   logic [NUM_REQ-1:0]       gnt_o;
   logic [OWN_W-1:0]         owner_o;
   logic                     busy_o;
   logic [NUM_REQ*PAD_W-1:0] req_out_i;
   logic [NUM_REQ*PAD_W-1:0] req_oeb_i;
   logic [NUM_REQ*PAD_W-1:0] req_in_o;
   logic [PAD_W-1:0]         io_in_i;
   logic [PAD_W-1:0]         io_out_o;
   logic [PAD_W-1:0]         io_oeb_o;

   modport slave (
      input  req_i, req_out_i, req_oeb_i, io_in_i,
      output gnt_o, owner_o, busy_o, req_in_o, io_out_o, io_oeb_o
   );

   modport master (
      output req_i, req_out_i, req_oeb_i, io_in_i,
      input  gnt_o, owner_o, busy_o, req_in_o, io_out_o, io_oeb_o
   );

endinterface

// File: rtl/io_pad_arbiter_rr_arbiter.sv
// Combinational round-robin priority search starting at a rotating pointer.
module rr_arbiter
   import io_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int OWN_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [OWN_W-1:0]   ptr,
   output logic               valid,
   output logic [OWN_W-1:0]   idx
);

   pick_t pick;

   assign pick  = rr_pick(MAX_REQ'(req), IDX_W'(ptr), NUM_REQ);
   assign valid = pick.valid;
   assign idx   = OWN_W'(pick.idx);

endmodule

// File: rtl/io_pad_arbiter.sv
// Shares one pad group among NUM_REQ requesters: round-robin grant, bounded hold
// with preemption, and an all-input turnaround between consecutive owners.
module io_pad_arbiter
   import io_arb_pkg::*;
#(
   parameter int NUM_REQ    = DEF_NUM_REQ,
   parameter int PAD_W      = DEF_PAD_W,
   parameter int MAX_HOLD   = DEF_MAX_HOLD,
   parameter int TURNAROUND = DEF_TURNAROUND
) (
   input logic             wb_clk_i,
   input logic             wb_rst_i,
   io_pad_arbiter_if.slave bus
);

   localparam int OWN_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
   localparam int TURN_W = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

   localparam logic [HOLD_W-1:0] HOLD_TOP  = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
   localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURNAROUND - 1);
   localparam logic [OWN_W-1:0]  OWN_LAST  = OWN_W'(NUM_REQ - 1);

   state_e              state_q, state_d;
   logic [OWN_W-1:0]    owner_q, owner_d;
   logic [OWN_W-1:0]    ptr_q, ptr_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [TURN_W-1:0]   turn_q, turn_d;

   logic                pick_valid;
   logic [OWN_W-1:0]    pick_idx;
   logic [NUM_REQ-1:0]  owner_oh;
   logic                release_req;
   logic                preempt;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .OWN_W   (OWN_W)
   ) u_rr (
      .req   (bus.req_i),
      .ptr   (ptr_q),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   always_comb begin
      owner_oh          = '0;
      owner_oh[owner_q] = 1'b1;
   end

   assign release_req = !bus.req_i[owner_q];
   assign preempt     = (MAX_HOLD != 0) && (hold_q == HOLD_TOP) && |(bus.req_i & ~owner_oh);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      hold_d  = hold_q;
      turn_d  = turn_q;
      unique case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               state_d = ST_GRANT;
               owner_d = pick_idx;
               hold_d  = '0;
            end
         end
         ST_GRANT: begin
            if (hold_q != HOLD_TOP) hold_d = hold_q + 1'b1;
            if (release_req || preempt) begin
               state_d = ST_TURN;
               turn_d  = '0;
               ptr_d   = (owner_q == OWN_LAST) ? '0 : OWN_W'(owner_q + 1'b1);
            end
         end
         ST_TURN: begin
            if (turn_q == TURN_LAST) begin
               if (pick_valid) begin
                  state_d = ST_GRANT;
                  owner_d = pick_idx;
                  hold_d  = '0;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               turn_d = turn_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= ST_IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
         hold_q  <= '0;
         turn_q  <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
         turn_q  <= turn_d;
      end
   end

   // Pads follow the registered owner only while granted; otherwise every pad is an input.
   always_comb begin
      bus.gnt_o    = '0;
      bus.io_out_o = '0;
      bus.io_oeb_o = '1;
      bus.req_in_o = '0;
      if (state_q == ST_GRANT) begin
         bus.gnt_o                             = owner_oh;
         bus.io_out_o                          = bus.req_out_i[int'(owner_q)*PAD_W +: PAD_W];
         bus.io_oeb_o                          = bus.req_oeb_i[int'(owner_q)*PAD_W +: PAD_W];
         bus.req_in_o[int'(owner_q)*PAD_W +: PAD_W] = bus.io_in_i;
      end
   end

   assign bus.owner_o = owner_q;
   assign bus.busy_o  = (state_q == ST_GRANT);

endmodule

// File: tb/tb_io_pad_arbiter.sv
// Randomized and directed checks of io_pad_arbiter against a cycle-level reference model.
module tb_io_pad_arbiter;

   localparam int N  = 4;
   localparam int PW = 5;
   localparam int MH = 8;
   localparam int TA = 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;

   io_pad_arbiter_if #(.NUM_REQ(N), .PAD_W(PW)) bus();

   io_pad_arbiter #(
      .NUM_REQ    (N),
      .PAD_W      (PW),
      .MAX_HOLD   (MH),
      .TURNAROUND (TA)
   ) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .bus      (bus.slave)
   );

   always #5 clk = ~clk;

   // Reference model: who holds the pads, how many cycles they have held them,
   // how many turnaround cycles remain, and where the next search starts.
   bit m_granted   = 1'b0;
   int m_owner     = 0;
   int m_held      = 0;
   int m_turn_left = 0;
   int m_ptr       = 0;

   function automatic int pick(input logic [N-1:0] req, input int ptr);
      for (int i = 0; i < N; i++)
         if (req[(ptr + i) % N]) return (ptr + i) % N;
      return -1;
   endfunction

   task automatic model_step(input logic [N-1:0] req, input logic r);
      int w;
      logic [N-1:0] others;
      if (r) begin
         m_granted = 1'b0; m_owner = 0; m_held = 0; m_turn_left = 0; m_ptr = 0;
      end else if (m_granted) begin
         others = req;
         others[m_owner] = 1'b0;
         if (!req[m_owner] || (MH != 0 && m_held >= MH && others != 0)) begin
            m_granted   = 1'b0;
            m_turn_left = TA;
            m_ptr       = (m_owner + 1) % N;
         end else begin
            m_held++;
         end
      end else if (m_turn_left > 1) begin
         m_turn_left--;
      end else begin
         m_turn_left = 0;
         w = pick(req, m_ptr);
         if (w >= 0) begin
            m_granted = 1'b1; m_owner = w; m_held = 1;
         end
      end
   endtask

   function automatic logic [36:0] expected();
      logic [N-1:0]    g  = '0;
      logic [PW-1:0]   o  = '0;
      logic [PW-1:0]   e  = '1;
      logic [N*PW-1:0] ri = '0;
      if (m_granted) begin
         g[m_owner]          = 1'b1;
         o                   = bus.req_out_i[m_owner*PW +: PW];
         e                   = bus.req_oeb_i[m_owner*PW +: PW];
         ri[m_owner*PW +: PW] = bus.io_in_i;
      end
      return {g, m_granted, 2'(m_owner), o, e, ri};
   endfunction

   function automatic logic [36:0] observed();
      return {bus.gnt_o, bus.busy_o, bus.owner_o, bus.io_out_o, bus.io_oeb_o, bus.req_in_o};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step(bus.req_i, rst);
      cyc++;
      #1;
   endtask

   task automatic randomize_pads();
      bus.req_out_i = N*PW'({$urandom, $urandom});
      bus.req_oeb_i = N*PW'({$urandom, $urandom});
      bus.io_in_i   = PW'($urandom);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.req_i = 4'b1111;
      randomize_pads();
      repeat (2) begin
         tick();
         n_checks++;
         if (bus.gnt_o !== 4'b0000 || bus.io_oeb_o !== 5'h1F || bus.io_out_o !== 5'h00 ||
             bus.busy_o !== 1'b0 || bus.req_in_o !== '0)
            $display("FAIL reset cyc %0d: gnt=%b oeb=%h out=%h busy=%b req_in=%h, want 0000/1f/00/0/0",
                     cyc, bus.gnt_o, bus.io_oeb_o, bus.io_out_o, bus.busy_o, bus.req_in_o);
         else n_pass++;
      end
      rst = 1'b0;
      bus.req_i = '0;
   endtask

   task automatic test_single();
      randomize_pads();
      bus.req_out_i[2*PW +: PW] = 5'h15;
      bus.req_oeb_i[2*PW +: PW] = 5'h00;
      bus.req_i = 4'b0100;
      tick();
      n_checks++;
      if (bus.gnt_o !== 4'b0100 || bus.io_out_o !== 5'h15 || bus.io_oeb_o !== 5'h00)
         $display("FAIL single_grant: gnt=%b out=%h oeb=%h, want 0100/15/00",
                  bus.gnt_o, bus.io_out_o, bus.io_oeb_o);
      else n_pass++;
      n_checks++;
      if (observed() !== expected())
         $display("FAIL single_model: got %h want %h", observed(), expected());
      else n_pass++;
      bus.req_i = 4'b0000;
      tick();
      n_checks++;
      if (bus.gnt_o !== 4'b0000 || bus.io_oeb_o !== 5'h1F || bus.io_out_o !== 5'h00)
         $display("FAIL single_turn: gnt=%b oeb=%h out=%h, want 0000/1f/00",
                  bus.gnt_o, bus.io_oeb_o, bus.io_out_o);
      else n_pass++;
      tick();
      n_checks++;
      if (bus.busy_o !== 1'b0 || bus.io_oeb_o !== 5'h1F || observed() !== expected())
         $display("FAIL single_idle: busy=%b oeb=%h got %h want %h",
                  bus.busy_o, bus.io_oeb_o, observed(), expected());
      else n_pass++;
   endtask

   task automatic test_round_robin();
      int   order[$];
      logic prev_busy = 1'b0;
      bus.req_i = 4'b1111;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int c = 0; c < 40 && order.size() < 5; c++) begin
         tick();
         n_checks++;
         if (observed() !== expected())
            $display("FAIL rr_cycle cyc %0d: got %h want %h", cyc, observed(), expected());
         else n_pass++;
         if (bus.busy_o && !prev_busy) order.push_back(int'(bus.owner_o));
         prev_busy = bus.busy_o;
         bus.req_i = 4'b1111;
         if (m_granted && m_held == 3) bus.req_i[m_owner] = 1'b0;
      end
      n_checks++;
      if (order.size() != 5)
         $display("FAIL rr_grants: got %0d grants, want 5", order.size());
      else n_pass++;
      for (int i = 0; i < order.size(); i++) begin
         n_checks++;
         if (order[i] != i % N)
            $display("FAIL rr_order[%0d]: got %0d want %0d", i, order[i], i % N);
         else n_pass++;
      end
      bus.req_i = '0;
   endtask

   task automatic test_preempt();
      int   order[$];
      int   first_stint = 0;
      logic prev_busy = 1'b0;
      int   want[3] = '{0, 3, 0};
      bus.req_i = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int c = 0; c < 22; c++) begin
         bus.req_i = 4'b0001;
         if (c >= 2 && c < 15) bus.req_i[3] = 1'b1;
         tick();
         n_checks++;
         if (observed() !== expected())
            $display("FAIL preempt_cycle cyc %0d: got %h want %h", cyc, observed(), expected());
         else n_pass++;
         if (bus.busy_o && !prev_busy) order.push_back(int'(bus.owner_o));
         prev_busy = bus.busy_o;
         if (order.size() == 1 && bus.gnt_o === 4'b0001) first_stint++;
      end
      n_checks++;
      if (first_stint != MH)
         $display("FAIL preempt_hold: req0 held %0d cycles, want %0d", first_stint, MH);
      else n_pass++;
      n_checks++;
      if (order.size() != 3)
         $display("FAIL preempt_grants: got %0d grants, want 3", order.size());
      else n_pass++;
      for (int i = 0; i < 3 && i < order.size(); i++) begin
         n_checks++;
         if (order[i] != want[i])
            $display("FAIL preempt_order[%0d]: got %0d want %0d", i, order[i], want[i]);
         else n_pass++;
      end
      bus.req_i = '0;
   endtask

   task automatic test_no_contender();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.req_i = 4'b0010;
      for (int c = 0; c < 100; c++) begin
         tick();
         n_checks++;
         if (bus.gnt_o !== 4'b0010)
            $display("FAIL hold_alone cyc %0d: gnt=%b want 0010", cyc, bus.gnt_o);
         else n_pass++;
      end
      bus.req_i = '0;
   endtask

   task automatic test_reset_mid_grant();
      logic [N*PW-1:0] want_in;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      randomize_pads();
      bus.req_out_i[1*PW +: PW] = 5'h1F;
      bus.req_oeb_i[1*PW +: PW] = 5'h00;
      bus.req_i = 4'b0010;
      tick();
      tick();
      want_in = '0;
      want_in[1*PW +: PW] = bus.io_in_i;
      n_checks++;
      if (bus.io_out_o !== 5'h1F || bus.io_oeb_o !== 5'h00 || bus.req_in_o !== want_in)
         $display("FAIL midrst_drive: out=%h oeb=%h req_in=%h, want 1f/00/%h",
                  bus.io_out_o, bus.io_oeb_o, bus.req_in_o, want_in);
      else n_pass++;
      rst = 1'b1;
      tick();
      n_checks++;
      if (bus.io_oeb_o !== 5'h1F || bus.gnt_o !== 4'b0000 || bus.req_in_o !== '0 || bus.busy_o !== 1'b0)
         $display("FAIL midrst_release: oeb=%h gnt=%b req_in=%h busy=%b, want 1f/0000/0/0",
                  bus.io_oeb_o, bus.gnt_o, bus.req_in_o, bus.busy_o);
      else n_pass++;
      rst = 1'b0;
      bus.req_i = '0;
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 3) == 0) bus.req_i = N'($urandom);
         if ($urandom_range(0, 7) == 0) begin
            bus.req_out_i = N*PW'({$urandom, $urandom});
            bus.req_oeb_i = N*PW'({$urandom, $urandom});
         end
         bus.io_in_i = PW'($urandom);
         rst = ($urandom_range(0, 59) == 0);
         tick();
         n_checks++;
         if (observed() !== expected())
            $display("FAIL random cyc %0d: got %h want %h", cyc, observed(), expected());
         else n_pass++;
      end
      rst = 1'b0;
   endtask

   initial begin
      bus.req_i     = '0;
      bus.req_out_i = '0;
      bus.req_oeb_i = '1;
      bus.io_in_i   = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_preempt();
      test_no_contender();
      test_reset_mid_grant();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
